// File: rtl/trd_fetch_sched.sv
// Round-robin fetch scheduler for the barrel pipeline: each cycle picks the
// thread to fetch from the runnable mask and masks threads in miss back-off.
module trd_fetch_sched #(
  parameter int NTRD      = 8,
  parameter int BLOCK_CYC = 4,
  localparam int TW       = $clog2(NTRD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NTRD-1:0] run_trd,
  input  logic            stall,
  input  logic            i_miss,
  input  logic [TW-1:0]   i_miss_trd,
  input  logic            d_miss,
  input  logic [TW-1:0]   d_miss_trd,
  output logic [TW-1:0]   trd_if,
  output logic            trd_if_vld,
  output logic [NTRD-1:0] blocked,
  output logic            all_blocked
);

  // Handshake: trd_if_vld=1 marks trd_if as a real issue slot for that cycle;
  // there is no back-pressure other than stall, which freezes the selection.

  logic [3:0]      blk_cnt [NTRD];
  logic [TW-1:0]   rr_ptr;
  logic [NTRD-1:0] hit;
  logic [NTRD-1:0] elig;
  logic [TW-1:0]   grant;
  logic            grant_vld;
  logic [TW-1:0]   idx;

  always_comb begin
    hit     = '0;
    elig    = '0;
    blocked = '0;
    for (int k = 0; k < NTRD; k++) begin
      hit[k]     = (i_miss && (i_miss_trd == TW'(k))) || (d_miss && (d_miss_trd == TW'(k)));
      elig[k]    = run_trd[k] && (blk_cnt[k] == 4'd0) && !hit[k];
      blocked[k] = (blk_cnt[k] != 4'd0);
    end
  end

  // Search starts at rr_ptr and wraps; first eligible thread wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < NTRD; i++) begin
      idx = rr_ptr + TW'(i);
      if (!grant_vld && elig[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trd_if      <= '0;
      trd_if_vld  <= 1'b0;
      rr_ptr      <= '0;
      all_blocked <= 1'b0;
    end else if (!stall) begin
      all_blocked <= (run_trd != '0) && !grant_vld;
      trd_if_vld  <= grant_vld;
      if (grant_vld) begin
        trd_if <= grant;
        rr_ptr <= grant + TW'(1);
      end
    end
  end

  // Back-off counters keep running through stalls so the window is wall-clock.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NTRD; k++) begin
      if (rst || !run_trd[k]) begin
        blk_cnt[k] <= 4'd0;
      end else if (hit[k]) begin
        blk_cnt[k] <= 4'(BLOCK_CYC);
      end else if (blk_cnt[k] != 4'd0) begin
        blk_cnt[k] <= blk_cnt[k] - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_trd_fetch_sched.sv
// Scoreboard bench for trd_fetch_sched: timestamp-based back-off model plus
// round-robin search, expectations queued per cycle and checked by a monitor.
module tb_trd_fetch_sched;

  localparam int NTRD      = 8;
  localparam int BLOCK_CYC = 4;
  localparam int TW        = 3;
  localparam int W         = 32 + TW + 1 + 1 + NTRD;

  logic            clk = 1'b0;
  logic            rst;
  logic [NTRD-1:0] run_trd;
  logic            stall;
  logic            i_miss;
  logic [TW-1:0]   i_miss_trd;
  logic            d_miss;
  logic [TW-1:0]   d_miss_trd;
  logic [TW-1:0]   trd_if;
  logic            trd_if_vld;
  logic [NTRD-1:0] blocked;
  logic            all_blocked;

  trd_fetch_sched #(.NTRD(NTRD), .BLOCK_CYC(BLOCK_CYC)) dut (
    .clk(clk), .rst(rst), .run_trd(run_trd), .stall(stall),
    .i_miss(i_miss), .i_miss_trd(i_miss_trd),
    .d_miss(d_miss), .d_miss_trd(d_miss_trd),
    .trd_if(trd_if), .trd_if_vld(trd_if_vld),
    .blocked(blocked), .all_blocked(all_blocked)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // ready_at[k]: first cycle in which thread k is no longer in back-off.
  int            ready_at [NTRD];
  logic [TW-1:0] m_trd;
  logic          m_vld;
  logic          m_ab;
  int            m_ptr;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic step(input logic r, input logic [NTRD-1:0] run, input logic st,
                      input logic im, input int imt, input logic dm, input int dmt);
    int c;
    logic [NTRD-1:0] el;
    logic [NTRD-1:0] hitm;
    logic [NTRD-1:0] blk;
    logic found;
    int g;
    c = cyc;
    rst = r; run_trd = run; stall = st;
    i_miss = im; i_miss_trd = TW'(imt); d_miss = dm; d_miss_trd = TW'(dmt);
    if (r) begin
      for (int k = 0; k < NTRD; k++) ready_at[k] = 0;
      m_trd = '0; m_vld = 1'b0; m_ab = 1'b0; m_ptr = 0;
    end else begin
      for (int k = 0; k < NTRD; k++) begin
        hitm[k] = (im && imt == k) || (dm && dmt == k);
        el[k]   = run[k] && (c >= ready_at[k]) && !hitm[k];
      end
      if (!st) begin
        found = 1'b0; g = 0;
        for (int i = 0; i < NTRD; i++)
          if (!found && el[(m_ptr + i) % NTRD]) begin
            found = 1'b1; g = (m_ptr + i) % NTRD;
          end
        m_ab  = (run != 0) && (el == 0);
        m_vld = found;
        if (found) begin
          m_trd = TW'(g);
          m_ptr = (g + 1) % NTRD;
        end
      end
      for (int k = 0; k < NTRD; k++) begin
        if (!run[k])      ready_at[k] = 0;
        else if (hitm[k]) ready_at[k] = c + BLOCK_CYC + 1;
      end
    end
    for (int k = 0; k < NTRD; k++) blk[k] = (c + 1) < ready_at[k];
    exp_q.push_back({32'(c + 1), m_trd, m_vld, m_ab, blk});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NTRD-1:0] run, input int n);
    for (int i = 0; i < n; i++) step(1'b0, run, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int tag;
    while (exp_q.size() > 0 && int'(exp_q[0][W-1:W-32]) <= cyc) begin
      e = exp_q.pop_front();
      tag = int'(e[W-1:W-32]);
      checks++;
      if (tag != cyc) begin
        failures++;
        $display("FAIL stale_expect cyc=%0d tag=%0d", cyc, tag);
      end else if ({trd_if, trd_if_vld, all_blocked, blocked} !== e[W-33:0]) begin
        failures++;
        $display("FAIL cycle_out cyc=%0d got trd=%0d vld=%b ab=%b blk=%b want trd=%0d vld=%b ab=%b blk=%b",
                 cyc, trd_if, trd_if_vld, all_blocked, blocked,
                 e[W-33:W-35], e[W-36], e[W-37], e[NTRD-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NTRD-1:0] rv;
    int mode;
    // T1: rotation over all threads
    step(1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0);
    idle(8'hFF, 9);
    // T2: sparse mask then single thread
    step(1'b1, 8'h05, 1'b0, 1'b0, 0, 1'b0, 0);
    idle(8'h05, 4);
    idle(8'h01, 4);
    // T3: i_miss on thread 1 with two runnable threads
    step(1'b0, 8'h03, 1'b0, 1'b1, 1, 1'b0, 0);
    idle(8'h03, 7);
    // T4: d_miss on only thread, then both misses same thread same cycle
    idle(8'h01, 1);
    step(1'b0, 8'h01, 1'b0, 1'b0, 0, 1'b1, 0);
    idle(8'h01, 6);
    step(1'b0, 8'h01, 1'b0, 1'b1, 0, 1'b1, 0);
    idle(8'h01, 6);
    // T5: stall with trd_if=3, miss issued during stall
    step(1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0);
    idle(8'hFF, 4);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b0, 8'hFF, 1'b1, 1'b1, 6, 1'b0, 0);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0);
    idle(8'hFF, 8);
    // T6: back-off on thread 5 dropped when it stops running; mid-stream reset
    step(1'b0, 8'hFF, 1'b0, 1'b0, 0, 1'b1, 5);
    idle(8'hFF, 2);
    idle(8'hDF, 2);
    idle(8'hFF, 2);
    step(1'b0, 8'hFF, 1'b0, 1'b1, 2, 1'b1, 4);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0);
    idle(8'hFF, 3);
    // Randomized traffic
    rv = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        mode = $urandom_range(0, 3);
        case (mode)
          0: rv = NTRD'($urandom);
          1: rv = NTRD'(1) << $urandom_range(0, NTRD - 1);
          2: rv = 8'hFF;
          default: rv = NTRD'($urandom) | NTRD'($urandom);
        endcase
      end
      step($urandom_range(0, 99) < 2, rv, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 25, $urandom_range(0, NTRD - 1),
           $urandom_range(0, 99) < 25, $urandom_range(0, NTRD - 1));
    end
    idle(rv, 2);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
